// File: rtl/reg_rr_arbiter.sv
// Round-robin arbiter sharing one register-bus target between NumReq initiators.
// An Idle cycle picks the next requester from rr_ptr upward and registers it.
// The Busy state then forwards that requester to the target until mst_ready_i.
// Only one transaction is outstanding at a time.
module reg_rr_arbiter #(
  parameter int NumReq = 4,
  parameter int AW     = 32,
  parameter int DW     = 32,
  localparam int IdxW  = $clog2(NumReq)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NumReq-1:0]      slv_valid_i,
  input  logic [NumReq-1:0]      slv_write_i,
  input  logic [NumReq*AW-1:0]   slv_addr_i,
  input  logic [NumReq*DW-1:0]   slv_wdata_i,
  input  logic [NumReq*DW/8-1:0] slv_wstrb_i,
  output logic [NumReq-1:0]      slv_ready_o,
  output logic [DW-1:0]          slv_rdata_o,
  output logic                   slv_error_o,
  output logic                   mst_valid_o,
  output logic                   mst_write_o,
  output logic [AW-1:0]          mst_addr_o,
  output logic [DW-1:0]          mst_wdata_o,
  output logic [DW/8-1:0]        mst_wstrb_o,
  input  logic                   mst_ready_i,
  input  logic [DW-1:0]          mst_rdata_i,
  input  logic                   mst_error_i,
  output logic [IdxW-1:0]        gnt_idx_o,
  output logic                   busy_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0] sel_idx;
  logic [IdxW-1:0] cand;
  logic            sel_found;

  // Modular add for indices; NumReq need not be a power of two, so wrap explicitly.
  function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] base,
                                               input int unsigned     off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= 32'(NumReq)) sum = sum - 32'(NumReq);
    return IdxW'(sum);
  endfunction

  // Find the first valid requester at or above rr_ptr, wrapping to 0.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NumReq; k++) begin
      cand = wrap_add(rr_ptr_q, k);
      if (!sel_found && slv_valid_i[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // State, round-robin pointer and grant registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      gnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_q    <= gnt_d;
    end
  end

  // Next-state logic plus the handshake outputs that depend on state.
  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = gnt_q;
    mst_valid_o = 1'b0;
    slv_ready_o = '0;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          gnt_d   = sel_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        mst_valid_o = 1'b1;
        if (mst_ready_i) begin
          slv_ready_o = NumReq'(1) << gnt_q;
          rr_ptr_d    = wrap_add(gnt_q, 1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Target-side fields follow the granted requester; mst_valid_o qualifies them.
  assign mst_write_o = slv_write_i[gnt_q];
  assign mst_addr_o  = slv_addr_i[gnt_q*AW +: AW];
  assign mst_wdata_o = slv_wdata_i[gnt_q*DW +: DW];
  assign mst_wstrb_o = slv_wstrb_i[gnt_q*(DW/8) +: DW/8];

  // Response data is shared and qualified only by slv_ready_o.
  assign slv_rdata_o = mst_rdata_i;
  assign slv_error_o = mst_error_i;

  assign gnt_idx_o = gnt_q;
  assign busy_o    = (state_q == BUSY);

endmodule
